// File: rtl/ysyx_24080006_ialign.sv
// Instruction realignment buffer: queues 16-bit parcels from 32-bit fetch words
// and hands the decoder one whole (compressed or 32-bit) instruction per handshake.
module ysyx_24080006_ialign #(
    parameter bit RVC         = 1'b1,
    parameter int FETCH_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_inst,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_compressed,
    output logic        out_err
);

    localparam int HQ = 2 * FETCH_DEPTH;
    localparam int PW = (HQ > 1) ? $clog2(HQ) : 1;
    localparam int CW = $clog2(HQ + 1);
    localparam logic [CW-1:0] CNT_ROOM = CW'(HQ - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_TWO  = CW'(2);

    logic [15:0]    parcels [HQ];
    logic [PW-1:0]  rd_ptr;
    logic [PW-1:0]  wr_ptr;
    logic [CW-1:0]  cnt;
    logic [31:0]    head_pc;

    logic [15:0]    p0;
    logic [15:0]    p1;
    logic           head_c;
    logic           have_inst;
    logic           push;
    logic           pop;
    logic           push_half;
    logic [CW-1:0]  n_push;
    logic [CW-1:0]  n_pop;
    logic           unused_pc_lsb;

    assign unused_pc_lsb = in_pc[0];

    always_comb begin
        p0        = parcels[rd_ptr];
        p1        = parcels[rd_ptr + PW'(1)];
        head_c    = RVC && (p0[1:0] != 2'b11);
        have_inst = head_c ? (cnt >= CNT_ONE) : (cnt >= CNT_TWO);

        in_ready  = ~flush & (cnt <= CNT_ROOM);
        out_valid = ~flush & have_inst;

        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        // Without RVC a misaligned word still occupies two parcels and is flagged.
        push_half = RVC && in_pc[1];
        n_push    = push ? (push_half ? CNT_ONE : CNT_TWO) : '0;
        n_pop     = pop ? (head_c ? CNT_ONE : CNT_TWO) : '0;

        out_pc         = head_pc;
        out_inst       = head_c ? {16'h0000, p0} : {p1, p0};
        out_compressed = out_valid & head_c;
        out_err        = out_valid & ~RVC & ((p0[1:0] != 2'b11) | head_pc[1]);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            head_pc <= '0;
        end else if (flush) begin
            cnt    <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            cnt <= cnt + n_push - n_pop;
            if (push)
                wr_ptr <= wr_ptr + (push_half ? PW'(1) : PW'(2));
            if (pop)
                rd_ptr <= rd_ptr + (head_c ? PW'(1) : PW'(2));
            // Fetch is sequential, so in_pc matters only when the queue runs dry.
            if (push && (cnt == n_pop))
                head_pc <= {in_pc[31:1], 1'b0};
            else if (pop)
                head_pc <= head_pc + (head_c ? 32'd2 : 32'd4);
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            if (push_half) begin
                parcels[wr_ptr] <= in_inst[31:16];
            end else begin
                parcels[wr_ptr]          <= in_inst[15:0];
                parcels[wr_ptr + PW'(1)] <= in_inst[31:16];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_24080006_ialign.sv
// Directed bench for the realignment buffer: one RVC=1 instance and one RVC=0
// instance share stimulus; expected values are hand-computed constants.
module tb_ysyx_24080006_ialign;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_out_compressed, a_out_err;
    logic [31:0] a_out_pc, a_out_inst;
    logic        b_in_ready, b_out_valid, b_out_compressed, b_out_err;
    logic [31:0] b_out_pc, b_out_inst;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    ysyx_24080006_ialign #(.RVC(1'b1), .FETCH_DEPTH(2)) u_rvc (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
        .out_inst(a_out_inst), .out_compressed(a_out_compressed), .out_err(a_out_err)
    );

    ysyx_24080006_ialign #(.RVC(1'b0), .FETCH_DEPTH(2)) u_norvc (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
        .out_inst(b_out_inst), .out_compressed(b_out_compressed), .out_err(b_out_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_inst   = '0;
        out_ready = 1'b0;
        #12;
        check("rst_valid", {31'd0, a_out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
        check("rst_pc", a_out_pc, 32'h0);
        check("rst_b_valid", {31'd0, b_out_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Two compressed parcels in one word
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0001_4505;
        check("t1_no_comb", {31'd0, a_out_valid}, 32'd0);
        tick();
        in_valid = 1'b0;
        check("t1_valid0", {31'd0, a_out_valid}, 32'd1);
        check("t1_inst0", a_out_inst, 32'h0000_4505);
        check("t1_pc0", a_out_pc, 32'h8000_0000);
        check("t1_c0", {31'd0, a_out_compressed}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t1_inst1", a_out_inst, 32'h0000_0001);
        check("t1_pc1", a_out_pc, 32'h8000_0002);
        check("t1_c1", {31'd0, a_out_compressed}, 32'd1);
        tick();
        check("t1_empty", {31'd0, a_out_valid}, 32'd0);

        // Straddling 32-bit instruction held until the second word arrives
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0513_4505;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        check("t2_inst0", a_out_inst, 32'h0000_4505);
        check("t2_pc0", a_out_pc, 32'h8000_0000);
        tick();
        check("t2_partial", {31'd0, a_out_valid}, 32'd0);
        tick();
        check("t2_hold", {31'd0, a_out_valid}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h1234_5678; in_inst = 32'h0000_00A5;
        tick();
        in_valid = 1'b0;
        check("t2_valid1", {31'd0, a_out_valid}, 32'd1);
        check("t2_inst1", a_out_inst, 32'h00A5_0513);
        check("t2_pc1", a_out_pc, 32'h8000_0002);
        check("t2_c1", {31'd0, a_out_compressed}, 32'd0);
        tick();
        check("t2_inst2", a_out_inst, 32'h0000_0000);
        check("t2_pc2", a_out_pc, 32'h8000_0006);
        check("t2_c2", {31'd0, a_out_compressed}, 32'd1);
        tick();
        check("t2_empty", {31'd0, a_out_valid}, 32'd0);

        // Backpressure fills the two-word buffer
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0010; in_inst = 32'h00A5_0513;
        check("t3_rdy0", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("t3_rdy1", {31'd0, a_in_ready}, 32'd1);
        tick();
        check("t3_full", {31'd0, a_in_ready}, 32'd0);
        tick();
        check("t3_still_full", {31'd0, a_in_ready}, 32'd0);
        check("t3_pc0", a_out_pc, 32'h8000_0010);
        in_valid = 1'b0; out_ready = 1'b1;
        check("t3_no_rdy_path", {31'd0, a_in_ready}, 32'd0);
        tick();
        check("t3_rdy_back", {31'd0, a_in_ready}, 32'd1);
        check("t3_pc1", a_out_pc, 32'h8000_0014);
        check("t3_inst1", a_out_inst, 32'h00A5_0513);
        tick();
        check("t3_no_dup", {31'd0, a_out_valid}, 32'd0);

        // Flush with half a 32-bit instruction buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0102; in_inst = 32'h0513_0000;
        tick();
        check("t4_partial", {31'd0, a_out_valid}, 32'd0);
        flush = 1'b1; in_inst = 32'h4505_4505; out_ready = 1'b1;
        #1;
        check("t4_fl_rdy", {31'd0, a_in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("t4_after_fl", {31'd0, a_out_valid}, 32'd0);
        in_valid = 1'b1; in_pc = 32'h8000_0102; in_inst = 32'h4505_1234;
        tick();
        in_valid = 1'b0;
        check("t4_inst", a_out_inst, 32'h0000_4505);
        check("t4_pc", a_out_pc, 32'h8000_0102);
        check("t4_c", {31'd0, a_out_compressed}, 32'd1);
        out_ready = 1'b1;
        tick();
        check("t4_empty", {31'd0, a_out_valid}, 32'd0);

        // Asynchronous reset with three parcels buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0002; in_inst = 32'h0001_0000;
        tick();
        in_pc = 32'h8000_0004; in_inst = 32'h0001_4505;
        tick();
        in_valid = 1'b0;
        check("t5_pre_valid", {31'd0, a_out_valid}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_rst_valid", {31'd0, a_out_valid}, 32'd0);
        check("t5_rst_rdy", {31'd0, a_in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b1; in_pc = 32'h9000_0000; in_inst = 32'h00A5_0513;
        tick();
        in_valid = 1'b0;
        check("t5_pc", a_out_pc, 32'h9000_0000);
        check("t5_inst", a_out_inst, 32'h00A5_0513);

        // RVC=0 instance: illegal-encoding and misalignment flags
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = 32'h0000_4505;
        tick();
        check("t6_valid0", {31'd0, b_out_valid}, 32'd1);
        check("t6_err0", {31'd0, b_out_err}, 32'd1);
        check("t6_c0", {31'd0, b_out_compressed}, 32'd0);
        check("t6_inst0", b_out_inst, 32'h0000_4505);
        out_ready = 1'b1; in_pc = 32'h8000_0002; in_inst = 32'h00A5_0513;
        tick();
        check("t6_pc1", b_out_pc, 32'h8000_0002);
        check("t6_err1", {31'd0, b_out_err}, 32'd1);
        in_pc = 32'h8000_0004;
        tick();
        in_valid = 1'b0;
        check("t6_pc2", b_out_pc, 32'h8000_0004);
        check("t6_err2", {31'd0, b_out_err}, 32'd0);
        check("t6_valid2", {31'd0, b_out_valid}, 32'd1);
        tick();
        check("t6_empty", {31'd0, b_out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
